// File: rtl/keccak_dom_pkg.sv
// Shared definitions for the DOM-masked Keccak randomness source and its consumers.
// rand_bits() keeps the Z bus width identical between the RNG and the masked sbox.
package keccak_dom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } rng_state_e;

  localparam int unsigned LFSR_WIDTH  = 31;
  localparam int unsigned SEED_WIDTH  = 32;
  // Feedback taps for x^31 + x^28 + 1, as bit indices into the state.
  localparam int unsigned LFSR_TAP_HI = 30;
  localparam int unsigned LFSR_TAP_LO = 27;

  function automatic int unsigned rand_bits(input int unsigned shares, input bit less_rand);
    return (shares * shares - shares) / 2 * 5 - (less_rand ? 5 : 0);
  endfunction

endpackage

// File: rtl/keccak_dom_lfsr31.sv
// One 31-bit Fibonacci LFSR (x^31+x^28+1) with parallel load, step and hold.
// A zero seed is replaced by 1 so the register can never lock up at all-zero.
module keccak_dom_lfsr31
  import keccak_dom_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  output logic                  msb_o
);

  logic [LFSR_WIDTH-1:0] state_q, state_d;

  // Load has priority over step so a reseed never shifts the fresh seed.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? LFSR_WIDTH'(1) : seed_i;
    end else if (step_i) begin
      state_d = {state_q[LFSR_WIDTH-2:0], state_q[LFSR_TAP_HI] ^ state_q[LFSR_TAP_LO]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign msb_o = state_q[LFSR_WIDTH-1];

endmodule

// File: rtl/keccak_dom_rng.sv
// Fresh-randomness source for the DOM-masked chi layer: a bank of seeded LFSRs behind a valid/ready bus.
// Optional: define KECCAK_RNG_RESEED_EN to accept seed words while running (restarts seeding).
module keccak_dom_rng
  import keccak_dom_pkg::*;
#(
  parameter int unsigned SHARES        = 2,
  parameter int unsigned LESS_RAND     = 0,
  parameter int unsigned WARMUP_CYCLES = 64,
  localparam int unsigned RAND_BITS    = rand_bits(SHARES, LESS_RAND != 0)
) (
  input  logic                  ClkxCI,
  input  logic                  RstxRI,
  input  logic [SEED_WIDTH-1:0] SeedxDI,
  input  logic                  SeedValidxSI,
  output logic                  SeedReadyxSO,
  input  logic                  RandReadyxSI,
  output logic                  RandValidxSO,
  output logic [RAND_BITS-1:0]  ZxDO
);

  localparam int unsigned NUM_LFSR = RAND_BITS;
  localparam int unsigned IDX_W    = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1;
  localparam int unsigned WARM_W   = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_LFSR - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

`ifdef KECCAK_RNG_RESEED_EN
  localparam bit RESEED = 1'b1;
`else
  localparam bit RESEED = 1'b0;
`endif

  rng_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WARM_W-1:0]    warm_q, warm_d;
  logic                 seed_ready, rand_valid;
  logic                 seed_acc, rand_acc, step;
  logic [IDX_W-1:0]     load_idx;
  logic [NUM_LFSR-1:0]  load_vec;
  logic [NUM_LFSR-1:0]  z_raw;
  logic                 unused_seed_msb;

  assign unused_seed_msb = SeedxDI[SEED_WIDTH-1];

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = SEED;
      SEED: begin
        if (seed_acc && idx_q == IDX_LAST) begin
          state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
        end
      end
      WARMUP: begin
        if (warm_q == WARM_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (seed_acc) begin
          state_d = SEED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    seed_ready = 1'b0;
    rand_valid = 1'b0;
    unique case (state_q)
      SEED: seed_ready = 1'b1;
      RUN: begin
        rand_valid = 1'b1;
        seed_ready = RESEED;
      end
      default: ;
    endcase
  end

  // A seed accepted in RUN takes precedence over a same-cycle consumer transfer.
  assign seed_acc = SeedValidxSI & seed_ready;
  assign rand_acc = RandReadyxSI & rand_valid & ~seed_acc;
  assign step     = (state_q == WARMUP) | rand_acc;
  assign load_idx = (state_q == RUN) ? '0 : idx_q;

  always_comb begin
    idx_d = idx_q;
    if (state_q == IDLE) begin
      idx_d = '0;
    end else if (seed_acc) begin
      if (state_q == RUN) begin
        idx_d = IDX_W'(1);
      end else if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    warm_d = '0;
    if (state_q == WARMUP && warm_q != WARM_LAST) begin
      warm_d = warm_q + WARM_W'(1);
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      idx_q  <= '0;
      warm_q <= '0;
    end else begin
      idx_q  <= idx_d;
      warm_q <= warm_d;
    end
  end

  always_comb begin
    load_vec = '0;
    for (int unsigned k = 0; k < NUM_LFSR; k++) begin
      load_vec[k] = seed_acc && (load_idx == IDX_W'(k));
    end
  end

  for (genvar k = 0; k < NUM_LFSR; k++) begin : g_lfsr
    keccak_dom_lfsr31 u_lfsr (
      .clk_i  (ClkxCI),
      .rst_i  (RstxRI),
      .load_i (load_vec[k]),
      .step_i (step),
      .seed_i (SeedxDI[LFSR_WIDTH-1:0]),
      .msb_o  (z_raw[k])
    );
  end

  assign SeedReadyxSO = seed_ready;
  assign RandValidxSO = rand_valid;
  assign ZxDO         = rand_valid ? z_raw : '0;

endmodule
